// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO onto an async serial line: 8N1, or 8E1 when UART_TX_PARITY_EN is defined.
// READ and LOAD each take one cycle before the start bit; frames run back-to-back while the FIFO has data.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  output logic       rd,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  logic bit_end;
  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  assign rd      = (state_q == S_READ);
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            state_q <= S_READ;
            busy_q  <= 1'b1;
          end
        end
        S_READ: state_q <= S_LOAD;
        S_LOAD: begin
          shift_q  <= din;
`ifdef UART_TX_PARITY_EN
          parity_q <= ^din;
`endif
          cnt_q    <= '0;
          bit_q    <= '0;
          tx_q     <= 1'b0;
          state_q  <= S_START;
        end
        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              // The shift register always presents the next bit in position 1.
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        S_STOP: begin
          // Registered pulse lands on the final stop-bit cycle.
          if (cnt_q == CW'(CLKS_PER_BIT - 2)) done_q <= 1'b1;
          if (bit_end) begin
            cnt_q <= '0;
            if (!fifo_empty) begin
              state_q <= S_READ;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with CLKS_PER_BIT=4: constant frame table, reset/backpressure/mid-frame-reset
// sequences, and random byte bursts checked against a cycle-position model of the serial line.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic       rd;
  logic [7:0] din;
  logic       tx;
  logic       busy;
  logic       tx_done;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .rd         (rd),
    .din        (din),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;

  logic [7:0]  fifo_q[$];
  logic        hold_empty;
  logic [7:0]  push_bytes[$];
  logic [10:0] exp_frames[$];
  logic [3:0]  rec[0:255];
  logic [3:0]  expv[0:255];

  typedef struct {
    logic [7:0]  d;
    logic [10:0] frame;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    assertions++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // One clock; the FIFO model presents the popped byte the cycle after rd.
  task automatic tick();
    logic rd_was;
    rd_was = rd;
    @(posedge clk);
    #1;
    if (rd_was === 1'b1 && fifo_q.size() > 0) din = fifo_q.pop_front();
    fifo_empty = hold_empty || (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = hold_empty || (fifo_q.size() == 0);
  endtask

  // Cycle 0 is the current cycle, in which fifo_empty is low with the DUT idle.
  task automatic run_frames(input string name);
    int n, f, len, r, s, bad;
    string sn;
    n   = exp_frames.size();
    f   = FB * CPB;
    len = 3 + n * (f + 2) + 3;
    for (int c = 0; c < len; c++) expv[c] = 4'b1000;
    for (int j = 0; j < n; j++) begin
      r = 1 + j * (f + 2);
      s = r + 2;
      expv[r][2] = 1'b1;
      for (int c = r; c < s + f; c++) expv[c][1] = 1'b1;
      for (int b = 0; b < FB; b++)
        for (int t = 0; t < CPB; t++) expv[s + b * CPB + t][3] = exp_frames[j][b];
      expv[s + f - 1][0] = 1'b1;
    end
    foreach (push_bytes[i]) push(push_bytes[i]);
    for (int c = 0; c < len; c++) begin
      if (c > 0) tick();
      rec[c] = {tx, rd, busy, tx_done};
    end
    for (int k = 0; k < 4; k++) begin
      bad = -1;
      for (int c = 0; c < len; c++) if (bad < 0 && rec[c][k] !== expv[c][k]) bad = c;
      sn = (k == 3) ? "tx" : (k == 2) ? "rd" : (k == 1) ? "busy" : "tx_done";
      assertions++;
      if (bad >= 0) begin
        failures++;
        $display("FAIL %s %s at cycle %0d: actual %b required %b", name, sn, bad, rec[bad][k], expv[bad][k]);
      end
    end
    push_bytes.delete();
    exp_frames.delete();
  endtask

  initial begin
    int r1, r2, d1, gap, cnt_rd, cnt_done, cnt_low, c_rel, c;
    logic [7:0] b;

    tbl[0] = '{8'hA5, FB == 11 ? 11'b10101001010 : 11'b01101001010};
    tbl[1] = '{8'h07, FB == 11 ? 11'b11000001110 : 11'b01000001110};
    tbl[2] = '{8'h00, FB == 11 ? 11'b10000000000 : 11'b01000000000};
    tbl[3] = '{8'hFF, FB == 11 ? 11'b10111111110 : 11'b01111111110};
    tbl[4] = '{8'h80, FB == 11 ? 11'b11100000000 : 11'b01100000000};
    tbl[5] = '{8'h3C, FB == 11 ? 11'b10001111000 : 11'b01001111000};

    rst = 1'b1; hold_empty = 1'b0; fifo_empty = 1'b1; din = 8'h00;
    tick();

    // Reset held with data waiting: outputs stay quiet; the frame follows release.
    push(8'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset tx %0d", i), tx, 1);
      check($sformatf("reset rd %0d", i), rd, 0);
      check($sformatf("reset busy %0d", i), busy, 0);
      check($sformatf("reset tx_done %0d", i), tx_done, 0);
    end
    rst = 1'b0;
    exp_frames.push_back(frame_of(8'h55));
    run_frames("after_reset");

    for (int i = 0; i < 6; i++) begin
      push_bytes.push_back(tbl[i].d);
      exp_frames.push_back(tbl[i].frame);
      run_frames($sformatf("table_%02h", tbl[i].d));
    end

    // Back-to-back 0x00 then 0xFF.
    push_bytes.push_back(8'h00); push_bytes.push_back(8'hFF);
    exp_frames.push_back(frame_of(8'h00)); exp_frames.push_back(frame_of(8'hFF));
    run_frames("b2b");
    r1 = -1; r2 = -1; d1 = -1;
    for (int i = 0; i < 200; i++) begin
      if (rec[i][2] === 1'b1) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      if (d1 < 0 && rec[i][0] === 1'b1) d1 = i;
    end
    check("b2b rd spacing", r2 - r1, FB * CPB + 2);
    gap = 0;
    for (int i = d1 + 1; i < 200 && rec[i][3] === 1'b1; i++) gap++;
    check("b2b idle gap", gap, 2);

    // fifo_empty forced high mid-frame, released after the frame has ended.
    push(8'h3C); push(8'hC3);
    c_rel = 3 + FB * CPB + 4;
    cnt_rd = 0; cnt_done = 0;
    for (c = 0; c <= c_rel; c++) begin
      if (c > 0) tick();
      if (c == 5) hold_empty = 1'b1;
      if (c == c_rel) hold_empty = 1'b0;
      fifo_empty = hold_empty || (fifo_q.size() == 0);
      if (rd === 1'b1) cnt_rd++;
      if (tx_done === 1'b1) cnt_done++;
    end
    check("hold rd count", cnt_rd, 1);
    check("hold done count", cnt_done, 1);
    check("hold busy idle", busy, 0);
    tick();
    check("hold rd after release", rd, 1);
    for (int i = 0; i < FB * CPB + 5; i++) begin
      tick();
      if (tx_done === 1'b1) cnt_done++;
    end
    check("hold done total", cnt_done, 2);

    // Reset during data bit 3 of 0xF7 (bit 3 is 0).
    push(8'hF7);
    cnt_done = 0;
    for (c = 0; c <= 20; c++) begin
      if (c > 0) tick();
      if (tx_done === 1'b1) cnt_done++;
    end
    check("midrst tx bit3", tx, 0);
    rst = 1'b1;
    tick();
    check("midrst tx", tx, 1);
    check("midrst busy", busy, 0);
    rst = 1'b0;
    cnt_rd = 0; cnt_low = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rd === 1'b1) cnt_rd++;
      if (tx_done === 1'b1) cnt_done++;
      if (tx !== 1'b1) cnt_low++;
    end
    check("midrst no done", cnt_done, 0);
    check("midrst no reread", cnt_rd, 0);
    check("midrst line idle", cnt_low, 0);
    push(8'h12);
    tick();
    check("midrst fresh rd", rd, 1);
    for (int i = 0; i < FB * CPB + 5; i++) begin
      tick();
      if (tx_done === 1'b1) cnt_done++;
    end
    check("midrst fresh done", cnt_done, 1);

    // Random bursts against the model.
    for (int k = 0; k < 5; k++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        push_bytes.push_back(b);
        exp_frames.push_back(frame_of(b));
      end
      run_frames($sformatf("random_%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
